// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and
// the legal operand-width range.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int WIDTH_MIN = 32'd2;
    localparam int WIDTH_MAX = 32'd32;

endpackage : serial_adder_pkg

// File: rtl/full_adder_bit.sv
// One-bit full adder built from gates; used as the single bit cell of the
// serial adder. Purely combinational.
module full_adder_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic ab_xor_s;
    logic ab_and_s;
    logic cx_and_s;

    xor g_x1 (ab_xor_s, a, b);
    xor g_x2 (s, ab_xor_s, cin);
    and g_a1 (ab_and_s, a, b);
    and g_a2 (cx_and_s, ab_xor_s, cin);
    or  g_o1 (cout, ab_and_s, cx_and_s);

endmodule : full_adder_bit

// File: rtl/serial_adder.sv
// Bit-serial, LSB-first adder: WIDTH-bit A + B + Cin in WIDTH RUN cycles
// through one full_adder_bit and a carry flop, with a start/busy/done
// handshake. The result holds until the next accepted start.
// Optional feature: define SERIAL_ADDER_OVF_EN to add the signed-overflow
// output Ovf.
// WIDTH legal range is WIDTH_MIN..WIDTH_MAX from serial_adder_pkg.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Sum,
`ifdef SERIAL_ADDER_OVF_EN
    output logic             Cout,
    output logic             Ovf
`else
    output logic             Cout
`endif
);

    localparam int             CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST_CNT = CW'(WIDTH - 1);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

    state_e           state_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] sum_r;
    logic [CW-1:0]    cnt_r;
    logic             carry_r;
    logic             cout_r;
    logic             busy_r;
    logic             done_r;
    logic             fa_s;
    logic             fa_cout_s;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf_r;
`endif

    // The single bit cell works on the current LSBs and the carry flop.
    full_adder_bit u_fa (
        .a    (a_r[0]),
        .b    (b_r[0]),
        .cin  (carry_r),
        .s    (fa_s),
        .cout (fa_cout_s)
    );

    // FSM, operand/result shift registers, counter and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            a_r     <= '0;
            b_r     <= '0;
            sum_r   <= '0;
            cnt_r   <= '0;
            carry_r <= 1'b0;
            cout_r  <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_r   <= 1'b0;
`endif
        end else begin
            case (state_r)
                // DONE behaves like IDLE for start so back-to-back ops
                // lose no cycle; done only ever lasts one cycle.
                IDLE, DONE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        a_r     <= A;
                        b_r     <= B;
                        carry_r <= Cin;
                        cnt_r   <= '0;
                        sum_r   <= '0;
                        cout_r  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
                        ovf_r   <= 1'b0;
`endif
                        busy_r  <= 1'b1;
                        state_r <= RUN;
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                // One result bit per cycle; start is ignored here.
                RUN: begin
                    a_r     <= {1'b0, a_r[WIDTH-1:1]};
                    b_r     <= {1'b0, b_r[WIDTH-1:1]};
                    sum_r   <= {fa_s, sum_r[WIDTH-1:1]};
                    carry_r <= fa_cout_s;
                    if (cnt_r == LAST_CNT) begin
                        // carry_r is the carry into the MSB on this cycle.
                        cout_r  <= fa_cout_s;
`ifdef SERIAL_ADDER_OVF_EN
                        ovf_r   <= carry_r ^ fa_cout_s;
`endif
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        state_r <= DONE;
                    end else begin
                        cnt_r   <= cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign Sum  = sum_r;
    assign Cout = cout_r;
`ifdef SERIAL_ADDER_OVF_EN
    assign Ovf  = ovf_r;
`endif

endmodule : serial_adder

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder (WIDTH=8) with a
// scoreboard of expected results pushed at start and popped at done.
module tb_serial_adder;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Sum;
    logic             Cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic             Ovf;
`endif

    typedef struct {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
    } exp_t;

    exp_t exp_q[$];
    int   n_total = 0;
    int   n_pass  = 0;

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .Cin   (Cin),
        .busy  (busy),
        .done  (done),
        .Sum   (Sum),
`ifdef SERIAL_ADDER_OVF_EN
        .Cout  (Cout),
        .Ovf   (Ovf)
`else
        .Cout  (Cout)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_expect(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic cin);
        logic [WIDTH:0] full;
        exp_t e;
        full   = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
        e.sum  = full[WIDTH-1:0];
        e.cout = full[WIDTH];
        e.ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (full[WIDTH-1] != a[WIDTH-1]);
        exp_q.push_back(e);
    endtask

    // Drive one start for a single edge; Sum/Cout must be cleared on accept.
    task automatic launch(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic cin, input bit scored);
        A     = a;
        B     = b;
        Cin   = cin;
        start = 1'b1;
        if (scored) push_expect(a, b, cin);
        step();
        start = 1'b0;
        A     = 8'($urandom);
        B     = 8'($urandom);
        Cin   = 1'($urandom);
        check("accept_busy", {31'd0, busy}, 32'd1);
        check("accept_done", {31'd0, done}, 32'd0);
        check("accept_sum_clr", {24'd0, Sum}, 32'd0);
    endtask

    // Wait (bounded) for done; optionally pulse an ignored start at poke_at.
    task automatic wait_done(input string tag, input int poke_at);
        int   n;
        bit   seen;
        exp_t e;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < WIDTH + 4) begin
            if (n == poke_at) begin
                start = 1'b1;
                A     = 8'hFF;
                B     = 8'hFF;
                Cin   = 1'b1;
            end else begin
                start = 1'b0;
            end
            step();
            n++;
            if (done) seen = 1'b1;
            else if (n < WIDTH) check({tag, "_busy"}, {31'd0, busy}, 32'd1);
        end
        start = 1'b0;
        check({tag, "_seen"}, {31'd0, seen}, 32'd1);
        if (seen) begin
            check({tag, "_latency"}, n, WIDTH);
            check({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
            if (exp_q.size() == 0) begin
                check({tag, "_sb_empty"}, 32'd0, 32'd1);
            end else begin
                e = exp_q.pop_front();
                check({tag, "_sum"}, {24'd0, Sum}, {24'd0, e.sum});
                check({tag, "_cout"}, {31'd0, Cout}, {31'd0, e.cout});
`ifdef SERIAL_ADDER_OVF_EN
                check({tag, "_ovf"}, {31'd0, Ovf}, {31'd0, e.ovf});
`endif
            end
        end
    endtask

    initial begin
        int done_cnt;
        rst   = 1'b1;
        start = 1'b0;
        A     = '0;
        B     = '0;
        Cin   = 1'b0;
        step();
        step();
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_sum", {24'd0, Sum}, 32'd0);
        check("rst_cout", {31'd0, Cout}, 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
        check("rst_ovf", {31'd0, Ovf}, 32'd0);
`endif
        rst = 1'b0;
        step();

        // 0x5A + 0x3C: Sum 0x96, Cout 0, Ovf 1; then hold in IDLE.
        launch(8'h5A, 8'h3C, 1'b0, 1'b1);
        wait_done("op5a3c", -1);
        step();
        check("post_done_low", {31'd0, done}, 32'd0);
        step();
        step();
        check("hold_sum", {24'd0, Sum}, 32'h96);
        check("hold_cout", {31'd0, Cout}, 32'd0);
        check("hold_busy", {31'd0, busy}, 32'd0);

        // Carry out of the top with no signed overflow.
        launch(8'hFF, 8'h01, 1'b0, 1'b1);
        wait_done("opff01", -1);
        step();

        // Carry-in pushes into signed overflow.
        launch(8'h7F, 8'h00, 1'b1, 1'b1);
        wait_done("op7f00c", -1);
        step();

        // start mid-RUN must be ignored.
        launch(8'h10, 8'h20, 1'b0, 1'b1);
        wait_done("ignore_start", 3);
        step();
        check("ignore_no_restart", {31'd0, busy}, 32'd0);

        // Reset in the middle of RUN aborts without a done pulse.
        launch(8'h12, 8'h34, 1'b0, 1'b0);
        step();
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_sum", {24'd0, Sum}, 32'd0);
        check("abort_cout", {31'd0, Cout}, 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
        check("abort_ovf", {31'd0, Ovf}, 32'd0);
`endif
        done_cnt = 0;
        for (int i = 0; i < WIDTH + 4; i++) begin
            step();
            if (done) done_cnt++;
        end
        check("abort_no_done", done_cnt, 0);

        // Back-to-back: start in the DONE cycle is accepted immediately.
        launch(8'hA5, 8'h0F, 1'b1, 1'b1);
        wait_done("b2b_first", -1);
        launch(8'h01, 8'h02, 1'b0, 1'b1);
        wait_done("b2b_second", -1);
        step();

        check("sb_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_serial_adder
